pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Owns the architectural program counter and sequences the PC-update datapath for the MIPS Harvard core. It takes resolved redirects (taken branch or jump targets from the PC-update logic), enforces the single MIPS branch delay slot, holds the PC under fetch/memory stalls, and detects the halt condition (jump to HALT_ADDR). It sits between the PC-update logic and the instruction-memory address port.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value loaded on reset
HALT_ADDR, 32'h00000000, redirect target that terminates execution

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  1 = hold all state this cycle (instruction/data memory wait)
redirect_valid  input  1  current instruction at pc is a taken branch/jump
redirect_target  input  32  target address for redirect_valid
pc  output  32  address of instruction currently executing / being fetched
pc_plus4  output  32  pc + 4, combinational, fed back to PC-update logic
active  output  1  1 while executing; 0 once halted (or faulted)
in_delay_slot  output  1  1 when instruction at pc is a delay-slot instruction
instr_count  output  32  number of instructions retired since reset
fault  output  1  misaligned redirect detected (only with optional feature; tied 0 otherwise)

Behaviour:
- Reset (sync, highest priority, overrides stall): pc=RESET_VECTOR, state=RUN, active=1, in_delay_slot=0, pending target=0, instr_count=0, fault=0. Reset asserted mid-delay-slot discards the pending target.
- States: RUN, DELAY, HALTED, FAULT. in_delay_slot = (state==DELAY). active = (state==RUN or DELAY).
- An "advance" cycle is one with reset=0, stall=0, state in {RUN, DELAY}. Non-advance cycles hold every register; redirect_valid is ignored while stall=1 (the datapath must keep it asserted until stall drops).
- RUN, advance, redirect_valid=0: pc<=pc+4, stay RUN.
- RUN, advance, redirect_valid=1: pc<=pc+4 (delay slot), pending<=redirect_target, ->DELAY.
- DELAY, advance: if pending==HALT_ADDR: pc<=HALT_ADDR, ->HALTED; else pc<=pending, ->RUN. redirect_valid in DELAY (branch in delay slot) is ignored; no new pending captured.
- HALTED/FAULT: terminal until reset; pc, instr_count frozen; active=0.
- instr_count increments by 1 on every advance cycle (mod 2^32 wrap, no saturation).
- pc arithmetic: 32-bit unsigned, wraps 0xFFFFFFFC -> 0x00000000 silently (sequential wrap to HALT_ADDR does NOT halt; only a redirect does).
- Latency: redirect seen in cycle N -> delay slot at pc in N+1 -> target at pc in N+2 (no stalls).

Optional Feature:
PC_SEQ_ALIGN_CHECK_EN: when defined, a redirect captured in RUN with redirect_target[1:0]!=0 sets fault=1 on the following edge, pc holds the delay-slot address, state->FAULT, active=0. When undefined, redirect_target[1:0] are forced to 00 on capture, FAULT state is unreachable, fault is constant 0.

Test Plan:
- Reset then 3 advance cycles, no redirect -> pc 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C; instr_count=3; active=1.
- At pc=0xBFC00010 redirect_valid=1 target 0xBFC00100 -> next pc 0xBFC00014 with in_delay_slot=1, then pc 0xBFC00100 with in_delay_slot=0.
- Redirect to 0x00000000 -> delay slot executes, then pc=0x00000000, active=0; further clocks with redirects leave pc, instr_count unchanged.
- stall=1 for 4 cycles while in DELAY with redirect_valid=1 -> pc, pending, instr_count held; after stall drops, pc=pending target, second redirect ignored.
- Reset asserted during DELAY (pending 0xBFC00200), stall=1 simultaneously -> pc=0xBFC00000, state RUN, instr_count=0, pending discarded.
- With PC_SEQ_ALIGN_CHECK_EN: redirect target 0xBFC00102 -> fault=1, active=0, pc frozen at delay-slot address; without macro: same stimulus -> pc reaches 0xBFC00100, fault=0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bus between the PC-update datapath (master) and the PC sequencer (slave):
// redirect/stall requests in, architectural PC state out.
interface pc_sequencer_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        active;
  logic        in_delay_slot;
  logic [31:0] instr_count;
  logic        fault;

  modport master (
    output stall, redirect_valid, redirect_target,
    input  pc, pc_plus4, active, in_delay_slot, instr_count, fault
  );

  modport slave (
    input  stall, redirect_valid, redirect_target,
    output pc, pc_plus4, active, in_delay_slot, instr_count, fault
  );
endinterface

// File: rtl/pc_sequencer.sv
// Architectural PC owner: single branch delay slot, stall hold, halt on redirect to HALT_ADDR.
// Optional macro PC_SEQ_ALIGN_CHECK_EN traps misaligned redirect targets into a FAULT state.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {RUN, DELAY, HALTED, FAULT} state_t;

  state_t      state;
  logic [31:0] pc_r;
  logic [31:0] pending;
  logic [31:0] count;
  logic        active_r;
  logic        delay_r;
  logic        fault_r;

  // Only RUN and DELAY retire instructions; HALTED and FAULT hold until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      pc_r     <= RESET_VECTOR;
      pending  <= 32'h0;
      count    <= 32'h0;
      active_r <= 1'b1;
      delay_r  <= 1'b0;
      fault_r  <= 1'b0;
    end else if (!bus.stall) begin
      case (state)
        RUN: begin
          pc_r  <= pc_r + 32'd4;
          count <= count + 32'd1;
          if (bus.redirect_valid) begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
            pending <= bus.redirect_target;
`else
            pending <= bus.redirect_target & ~32'h3;
`endif
            state   <= DELAY;
            delay_r <= 1'b1;
          end
        end
        DELAY: begin
          count   <= count + 32'd1;
          delay_r <= 1'b0;
          if (pending == HALT_ADDR) begin
            pc_r     <= HALT_ADDR;
            state    <= HALTED;
            active_r <= 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
          end else if (pending[1:0] != 2'b00) begin
            state    <= FAULT;
            active_r <= 1'b0;
            fault_r  <= 1'b1;
`endif
          end else begin
            pc_r  <= pending;
            state <= RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.pc            = pc_r;
  assign bus.pc_plus4      = pc_r + 32'd4;
  assign bus.active        = active_r;
  assign bus.in_delay_slot = delay_r;
  assign bus.instr_count   = count;
`ifdef PC_SEQ_ALIGN_CHECK_EN
  assign bus.fault         = fault_r;
`else
  assign bus.fault         = 1'b0;
`endif

endmodule
